// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg
//   ID/EX pipeline register for the 5-stage RISC-V pipeline, with load-use
//   hazard detection, bubble insertion and taken-branch squash.
//
// Ports
//   clk, reset            : clock; asynchronous active-high reset
//   id_*                  : decoded instruction presented by ID
//   flush                 : squash the ID instruction (taken branch)
//   ex_*                  : registered instruction presented to EX
//   stall                 : combinational; hold PC and IF/ID this cycle
//   bubble_count          : saturating count of inserted bubbles
module id_ex_hazard_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic [1:0]       id_aluop,
    input  logic             id_alusrc,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic [1:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);

    // Control fields packed as {alusrc, branch, memread, memwrite, memtoreg, regwrite}
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       funct_q, funct_d;
    logic [1:0]       aluop_q, aluop_d;
    logic [5:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic bubble;

    // rs2 is compared even for instructions that do not read it; a spurious
    // one-cycle stall is cheaper than decoding the opcode here.
    assign load_use = valid_q & ctrl_q[3] & (rd_q != 5'd0) & id_valid &
                      ((rd_q == id_rs1) | (rd_q == id_rs2));

    // A flush already discards the dependent instruction, so holding the
    // front end would only lose the branch-target fetch.
    assign stall  = load_use & ~flush;
    assign bubble = flush | load_use;

    always_comb begin
        // Data fields follow ID even in a bubble; only valid/control are forced.
        valid_d    = id_valid;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
        funct_d    = id_funct;
        aluop_d    = id_aluop;
        ctrl_d     = {id_alusrc, id_branch, id_memread,
                      id_memwrite, id_memtoreg, id_regwrite};
        cnt_d      = cnt_q;

        if (bubble) begin
            // aluop 00 / funct 0000 decodes to ADD downstream: harmless.
            valid_d = 1'b0;
            rd_d    = 5'd0;
            funct_d = 4'd0;
            aluop_d = 2'b00;
            ctrl_d  = 6'd0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            funct_q    <= 4'd0;
            aluop_q    <= 2'b00;
            ctrl_q     <= 6'd0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
            aluop_q    <= aluop_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_funct     = funct_q;
    assign ex_aluop     = aluop_q;
    assign ex_alusrc    = ctrl_q[5];
    assign ex_branch    = ctrl_q[4];
    assign ex_memread   = ctrl_q[3];
    assign ex_memwrite  = ctrl_q[2];
    assign ex_memtoreg  = ctrl_q[1];
    assign ex_regwrite  = ctrl_q[0];
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic [1:0]  id_aluop;
    logic        id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite;
    logic        flush;

    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [1:0]  ex_aluop;
    logic        ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic        stall;
    logic [15:0] bubble_count;

    // Second instance with a 2-bit counter, fed only invalid instructions
    logic        flush2;
    logic        v2;
    logic        x2_valid;
    logic [63:0] x2_pc, x2_rs1_data, x2_rs2_data, x2_imm;
    logic [4:0]  x2_rs1, x2_rs2, x2_rd;
    logic [3:0]  x2_funct;
    logic [1:0]  x2_aluop;
    logic        x2_alusrc, x2_branch, x2_memread, x2_memwrite, x2_memtoreg, x2_regwrite;
    logic        x2_stall;
    logic [1:0]  bubble_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_branch(id_branch),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .stall(stall),
        .bubble_count(bubble_count)
    );

    id_ex_hazard_reg #(.XLEN(64), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(v2), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_branch(id_branch),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .flush(flush2),
        .ex_valid(x2_valid), .ex_pc(x2_pc), .ex_rs1_data(x2_rs1_data),
        .ex_rs2_data(x2_rs2_data), .ex_imm(x2_imm), .ex_rs1(x2_rs1), .ex_rs2(x2_rs2),
        .ex_rd(x2_rd), .ex_funct(x2_funct), .ex_aluop(x2_aluop), .ex_alusrc(x2_alusrc),
        .ex_branch(x2_branch), .ex_memread(x2_memread), .ex_memwrite(x2_memwrite),
        .ex_memtoreg(x2_memtoreg), .ex_regwrite(x2_regwrite), .stall(x2_stall),
        .bubble_count(bubble_count2)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic [1:0]  aluop;
        logic [5:0]  ctrl;   // {alusrc, branch, memread, memwrite, memtoreg, regwrite}
        logic [15:0] bub;
        logic [1:0]  bub2;
    } exp_t;

    exp_t sb[$];

    // Reference model state (what EX should hold after the last edge)
    logic        m_valid;
    logic        m_memread;
    logic [4:0]  m_rd;
    logic [15:0] m_bub;
    logic [1:0]  m_bub2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_memread = 1'b0;
        m_rd      = 5'd0;
        m_bub     = 16'd0;
        m_bub2    = 2'd0;
        sb.delete();
    endtask

    task automatic set_id(input logic vld, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] funct,
                          input logic [1:0] aluop, input logic [5:0] ctrl);
        id_valid    = vld;
        id_pc       = pc;
        id_rs1_data = pc ^ 64'hA5A5_0000_1234_5678;
        id_rs2_data = ~pc;
        id_imm      = {pc[31:0], 32'hFFFF_0008};
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_funct    = funct;
        id_aluop    = aluop;
        {id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite} = ctrl;
    endtask

    // Called just after a rising edge; checks stall mid-cycle, predicts, then
    // compares the registered result after the next edge.
    task automatic step(input string tag);
        logic lu, bub;
        exp_t e, r;
        #2;
        lu  = m_valid & m_memread & (m_rd != 5'd0) & id_valid &
              ((m_rd == id_rs1) | (m_rd == id_rs2));
        bub = flush | lu;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, lu & ~flush});
        e.pc = id_pc; e.d1 = id_rs1_data; e.d2 = id_rs2_data; e.imm = id_imm;
        e.rs1 = id_rs1; e.rs2 = id_rs2;
        if (bub) begin
            e.valid = 1'b0; e.rd = 5'd0; e.funct = 4'd0; e.aluop = 2'b00; e.ctrl = 6'd0;
            e.bub = (m_bub == 16'hFFFF) ? m_bub : m_bub + 16'd1;
        end else begin
            e.valid = id_valid; e.rd = id_rd; e.funct = id_funct; e.aluop = id_aluop;
            e.ctrl = {id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite};
            e.bub = m_bub;
        end
        e.bub2 = (flush2 && m_bub2 != 2'd3) ? m_bub2 + 2'd1 : m_bub2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s.sb scoreboard empty", tag);
        end else begin
            r = sb.pop_front();
            check({tag, ".valid"}, {63'd0, ex_valid}, {63'd0, r.valid});
            check({tag, ".rd"}, {59'd0, ex_rd}, {59'd0, r.rd});
            check({tag, ".funct"}, {60'd0, ex_funct}, {60'd0, r.funct});
            check({tag, ".aluop"}, {62'd0, ex_aluop}, {62'd0, r.aluop});
            check({tag, ".ctrl"},
                  {58'd0, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite},
                  {58'd0, r.ctrl});
            check({tag, ".bubcnt"}, {48'd0, bubble_count}, {48'd0, r.bub});
            check({tag, ".bubcnt2"}, {62'd0, bubble_count2}, {62'd0, r.bub2});
            if (r.valid) begin
                check({tag, ".pc"}, ex_pc, r.pc);
                check({tag, ".rs1_data"}, ex_rs1_data, r.d1);
                check({tag, ".rs2_data"}, ex_rs2_data, r.d2);
                check({tag, ".imm"}, ex_imm, r.imm);
                check({tag, ".rs1"}, {59'd0, ex_rs1}, {59'd0, r.rs1});
                check({tag, ".rs2"}, {59'd0, ex_rs2}, {59'd0, r.rs2});
            end
            m_valid   = r.valid;
            m_memread = r.ctrl[3];
            m_rd      = r.rd;
            m_bub     = r.bub;
            m_bub2    = r.bub2;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, {63'd0, ex_valid}, 64'd0);
        check({tag, ".stall"}, {63'd0, stall}, 64'd0);
        check({tag, ".bubcnt"}, {48'd0, bubble_count}, 64'd0);
        check({tag, ".bubcnt2"}, {62'd0, bubble_count2}, 64'd0);
        check({tag, ".pc"}, ex_pc, 64'd0);
        check({tag, ".rs1_data"}, ex_rs1_data, 64'd0);
        check({tag, ".imm"}, ex_imm, 64'd0);
        check({tag, ".rd"}, {59'd0, ex_rd}, 64'd0);
        check({tag, ".funct_aluop"}, {58'd0, ex_funct, ex_aluop}, 64'd0);
        check({tag, ".ctrl"},
              {58'd0, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite},
              64'd0);
    endtask

    // Control encodings {alusrc, branch, memread, memwrite, memtoreg, regwrite}
    localparam logic [5:0] C_RTYPE = 6'b000001;
    localparam logic [5:0] C_LOAD  = 6'b101011;

    logic [1:0] sat_seq [5];

    initial begin
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;
        reset  = 1'b1;
        flush  = 1'b0;
        flush2 = 1'b0;
        v2     = 1'b0;
        set_id(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 6'd0);
        model_reset();
        #2;
        check_all_zero("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // Pass-through: add x3,x1,x2
        set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 4'b0000, 2'b10, C_RTYPE);
        step("add");
        check("add.pc_exact", ex_pc, 64'h100);

        // Load-use: ld x5,0(x1) then sub x6,x5,x2
        set_id(1'b1, 64'h104, 5'd1, 5'd0, 5'd5, 4'b0011, 2'b00, C_LOAD);
        step("ld_x5");
        set_id(1'b1, 64'h108, 5'd5, 5'd2, 5'd6, 4'b1000, 2'b10, C_RTYPE);
        step("sub_stall");
        check("sub_stall.bubcnt_exact", {48'd0, bubble_count}, 64'd1);
        step("sub_go");
        check("sub_go.funct_exact", {60'd0, ex_funct}, 64'd8);

        // No hazard: load to x0, then a reader of x0
        set_id(1'b1, 64'h10C, 5'd1, 5'd0, 5'd0, 4'b0011, 2'b00, C_LOAD);
        step("ld_x0");
        set_id(1'b1, 64'h110, 5'd0, 5'd0, 5'd9, 4'b0000, 2'b10, C_RTYPE);
        step("use_x0");
        // No hazard: ld x5, then instruction using x7/x8 only
        set_id(1'b1, 64'h114, 5'd1, 5'd0, 5'd5, 4'b0011, 2'b00, C_LOAD);
        step("ld_x5b");
        set_id(1'b1, 64'h118, 5'd7, 5'd8, 5'd10, 4'b0111, 2'b10, C_RTYPE);
        step("and_x7x8");

        // Back-to-back dependent loads: ld x5; ld x6,0(x5); add x7,x6,x1
        set_id(1'b1, 64'h11C, 5'd1, 5'd0, 5'd5, 4'b0011, 2'b00, C_LOAD);
        step("bb_ld1");
        set_id(1'b1, 64'h120, 5'd5, 5'd0, 5'd6, 4'b0011, 2'b00, C_LOAD);
        step("bb_ld2_stall");
        step("bb_ld2_go");
        set_id(1'b1, 64'h124, 5'd1, 5'd6, 5'd7, 4'b0000, 2'b10, C_RTYPE);
        step("bb_add_stall");
        step("bb_add_go");

        // Invalid ID instruction passes through without counting
        set_id(1'b0, 64'h128, 5'd7, 5'd7, 5'd11, 4'b0000, 2'b10, C_RTYPE);
        step("invalid");

        // Flush together with load-use
        set_id(1'b1, 64'h12C, 5'd1, 5'd0, 5'd5, 4'b0011, 2'b00, C_LOAD);
        step("sim_ld");
        set_id(1'b1, 64'h130, 5'd2, 5'd5, 5'd6, 4'b1000, 2'b10, C_RTYPE);
        flush = 1'b1;
        step("sim_flush_lu");
        flush = 1'b0;
        check("sim.bubcnt_exact", {48'd0, bubble_count}, 64'd4);
        // Plain flush of a non-hazard instruction
        set_id(1'b1, 64'h134, 5'd1, 5'd2, 5'd3, 4'b0000, 2'b10, C_RTYPE);
        flush = 1'b1;
        step("flush_add");
        flush = 1'b0;

        // Saturation on the 2-bit counter instance
        set_id(1'b0, 64'h200, 5'd0, 5'd0, 5'd0, 4'd0, 2'b00, 6'd0);
        flush2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("sat");
            check("sat.seq", {62'd0, bubble_count2}, {62'd0, sat_seq[i]});
        end
        flush2 = 1'b0;

        // Asynchronous reset mid-stall
        set_id(1'b1, 64'h140, 5'd1, 5'd0, 5'd5, 4'b0011, 2'b00, C_LOAD);
        step("rst_ld");
        set_id(1'b1, 64'h144, 5'd5, 5'd2, 5'd6, 4'b1000, 2'b10, C_RTYPE);
        #2;
        check("rst.pre_stall", {63'd0, stall}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(posedge clk); #1;
        check_all_zero("rst_held");
        reset = 1'b0;
        set_id(1'b1, 64'h148, 5'd1, 5'd2, 5'd3, 4'b0000, 2'b10, C_RTYPE);
        step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V pipeline. Each cycle it captures the decoded instruction from ID (operands, immediate, register indices, the 2-bit ALU-op class and the 4-bit funct field) and presents them to EX, where the ALU control stage turns them into a 4-bit ALU operation. It detects a load followed by a dependent instruction, stalls PC and IF/ID for one cycle, and inserts a bubble. It also squashes the ID instruction on a taken-branch flush.

## Interface
- XLEN, 64, datapath width for the PC, operands and immediate
- CNT_W, 16, width of the saturating bubble counter

- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct  in  4  {instr[30], instr[14:12]}
- id_aluop  in  2  00 load/store, 01 branch, 10 R-type
- id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite  in  1  main-control outputs
- flush  in  1  taken branch resolved downstream; squash the ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies
- ex_funct  out  4  registered copy
- ex_aluop  out  2  registered copy
- ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1  registered copies
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_count  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- id_rs2 is compared for every instruction type. The check is deliberately conservative; no opcode decode is done here.
- stall = load_use & ~flush.
- Per-cycle priority at each rising edge:
  - **Flush:** if flush, load a bubble.
  - **Load-use:** else if load_use, load a bubble.
  - **Normal:** else capture all id_* into ex_*, with ex_valid = id_valid.
- A bubble sets:
  - ex_valid = 0 and all six control bits = 0;
  - ex_aluop = 00 and ex_funct = 0000, so the ALU control stage sees a harmless ADD;
  - ex_rd = 0.
- In a bubble, the data fields (pc, rs*_data, imm, rs1, rs2) may hold any value. The bench checks them only when ex_valid = 1.
- bubble_count increments by 1 on each edge that loads a bubble because of load_use or flush. It holds at 2^CNT_W−1. Invalid ID instructions passed through on a normal edge do not count.
- There is no state machine beyond the register itself. A dependent instruction stalls at most one cycle, because after the bubble ex_memread = 0.

## Timing
- Latency is 1 cycle from ID inputs to ex_* outputs.
- stall is purely combinational from ex_* registers and id_* inputs, and is valid within the same cycle.
- Reset is asynchronous. While reset = 1, every output is 0: ex_* all 0, ex_valid = 0, bubble_count = 0, and therefore stall = 0. Deassertion takes effect at the next rising edge.
- Reset mid-stall drops stall immediately, because ex_valid clears.
- flush and load_use in the same cycle: a bubble is loaded, stall = 0, and bubble_count increments by exactly 1.
- Back-to-back loads, where the second load depends on the first: this is one stall, then normal flow. The second load then creates its own hazard against the next instruction.
- ex_rd = 0 on a load never stalls.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle with valid traffic → all outputs 0 immediately, including stall = 0 and bubble_count = 0.
- **Pass-through:** add x3,x1,x2 (funct 0000, aluop 10), id_pc = 0x100 → next edge ex_funct = 0000, ex_aluop = 10, ex_rd = 3, ex_pc = 0x100, ex_valid = 1, stall = 0 throughout.
- **Load-use:**
  - Stimulus: ld x5,0(x1) in EX, then sub x6,x5,x2 in ID.
  - Stall cycle: stall = 1 for exactly one cycle; next edge ex_valid = 0, ex_aluop = 00, bubble_count = 1.
  - Following edge: ex_funct = 1000 with ex_valid = 1.
- **No hazard:**
  - ld x0 in EX with rs1 = 0 in ID → stall = 0.
  - ld x5 in EX with an ID instruction using only x7 and x8 → stall = 0.
- **Simultaneous events:** flush = 1 together with a load-use condition → stall = 0, bubble loaded, bubble_count increments by exactly 1.
- **Saturation:** with CNT_W = 2, force 5 flushes → bubble_count sequence 1, 2, 3, 3, 3.
